irq_pending_ctrl: RTL and testbench

Interrupt pending/claim controller for the SoC's 16 interrupt sources. It captures rising edges on the raw source lines and holds them as pending bits. It drives the masked pending vector into the 16-to-4 priority encoder and consumes the encoder's `id`/`valid` result, then runs a request/claim/complete handshake with the CPU trap logic. It sits directly upstream and downstream of the encoder: it both feeds the encoder's input and consumes its output.

---
 rtl/irq_pending_ctrl.sv | 127 ++++++++++++
 tb/tb_irq_pending_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_pending_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------------+
// | irq_pending_ctrl: edge-captured pending bits + mask + req/claim/complete FSM      |
// | Rev 1.0 -- optional macro IRQ_SYNC_EN adds a 2-flop synchronizer on irq_src        |
// +-----------------------------------------------------------------------------------+
module irq_pending_ctrl #(
  parameter logic [15:0] MASK_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] irq_src,
  input  logic        mask_we,
  input  logic [15:0] mask_wdata,
  output logic [15:0] enc_vec,
  input  logic [3:0]  enc_id,
  input  logic        enc_valid,
  output logic        irq_req,
  output logic [3:0]  irq_id,
  input  logic        irq_ack,
  input  logic        irq_done,
  output logic [15:0] pending,
  output logic [15:0] mask
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  state_e      state_q;
  logic [15:0] src_q;
  logic [15:0] pending_q;
  logic [15:0] pending_d;
  logic [15:0] mask_q;
  logic [15:0] mask_d;
  logic        irq_req_q;
  logic [3:0]  irq_id_q;
  logic [15:0] src_in;
  logic [15:0] rise;
  logic [15:0] clr;

`ifdef IRQ_SYNC_EN
  logic [15:0] sync1_q;
  logic [15:0] sync2_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_src;
      sync2_q <= sync1_q;
    end
  end

  assign src_in = sync2_q;
`else
  assign src_in = irq_src;
`endif

  assign rise = src_in & ~src_q;

  always_comb begin
    clr = '0;
    if (state_q == ST_REQ && irq_ack) begin
      clr[irq_id_q] = 1'b1;
    end
  end

  // A fresh edge on the claim cycle must survive the clear.
  assign pending_d = (pending_q & ~clr) | rise;
  assign mask_d    = mask_we ? mask_wdata : mask_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      src_q     <= '0;
      pending_q <= '0;
      mask_q    <= MASK_RESET;
    end else begin
      src_q     <= src_in;
      pending_q <= pending_d;
      mask_q    <= mask_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      irq_req_q <= 1'b0;
      irq_id_q  <= 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enc_valid) begin
            irq_id_q  <= enc_id;
            irq_req_q <= 1'b1;
            state_q   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (irq_ack) begin
            irq_req_q <= 1'b0;
            state_q   <= ST_SERVICE;
          end
        end
        ST_SERVICE: begin
          if (irq_done) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          irq_req_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign enc_vec = pending_q & mask_q;
  assign irq_req = irq_req_q;
  assign irq_id  = irq_id_q;
  assign pending = pending_q;
  assign mask    = mask_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_pending_ctrl.sv
`default_nettype none
// Bench for irq_pending_ctrl: directed scenarios then random traffic, scoreboarded
// against a transaction-level model; the bench also plays the priority encoder.
module tb_irq_pending_ctrl;

  localparam logic [15:0] MASK_RST = 16'hFFFF;
`ifdef IRQ_SYNC_EN
  localparam int SYNC_DEPTH = 2;
`else
  localparam int SYNC_DEPTH = 0;
`endif
  localparam int P_IDLE = 0;
  localparam int P_REQ  = 1;
  localparam int P_SVC  = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] irq_src = '0;
  logic        mask_we = 1'b0;
  logic [15:0] mask_wdata = '0;
  logic [15:0] enc_vec;
  logic [3:0]  enc_id;
  logic        enc_valid;
  logic        irq_req;
  logic [3:0]  irq_id;
  logic        irq_ack = 1'b0;
  logic        irq_done = 1'b0;
  logic [15:0] pending;
  logic [15:0] mask;

  irq_pending_ctrl #(.MASK_RESET(MASK_RST)) dut (
    .clk(clk), .rstn(rstn), .irq_src(irq_src), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .enc_vec(enc_vec), .enc_id(enc_id), .enc_valid(enc_valid), .irq_req(irq_req),
    .irq_id(irq_id), .irq_ack(irq_ack), .irq_done(irq_done), .pending(pending), .mask(mask)
  );

  always #5 clk = ~clk;

  // Environment's priority encoder: highest set index wins.
  always_comb begin
    enc_id = 4'd0;
    for (int i = 0; i < 16; i++) if (enc_vec[i]) enc_id = 4'(i);
  end
  assign enc_valid = |enc_vec;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { logic [3:0] id; int cyc; } exp_t;
  exp_t exp_q[$];

  // Reference model state.
  logic [15:0] m_pend, m_mask, m_prev;
  logic [15:0] dly[$];
  int          m_phase;
  logic [3:0]  m_id;
  bit          m_valid = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Hand-derived timing points only hold without the input synchronizer.
  task automatic spot(input string nm, input logic [31:0] act, input logic [31:0] exp);
`ifndef IRQ_SYNC_EN
    check(nm, act, exp);
`endif
  endtask

  function automatic logic [3:0] top_bit(input logic [15:0] v);
    logic [3:0] r = 4'd0;
    for (int i = 0; i < 16; i++) if (v[i]) r = 4'(i);
    return r;
  endfunction

  task automatic model_update(input bit r, input logic [15:0] s, input bit we,
                              input logic [15:0] wd, input bit a, input bit d);
    logic [15:0] eff, rise, vis;
    if (!r) begin
      m_pend = '0; m_mask = MASK_RST; m_prev = '0; m_phase = P_IDLE; m_id = 4'd0;
      dly.delete();
      repeat (SYNC_DEPTH) dly.push_back(16'h0000);
      m_valid = 1'b1;
    end else begin
      dly.push_back(s);
      eff    = dly.pop_front();
      rise   = eff & ~m_prev;
      m_prev = eff;
      vis    = m_pend & m_mask;
      case (m_phase)
        P_IDLE: if (vis != 16'h0) begin
          m_id = top_bit(vis);
          m_phase = P_REQ;
          exp_q.push_back('{id: m_id, cyc: cyc + 1});
        end
        P_REQ: if (a) begin
          m_pend[m_id] = 1'b0;
          m_phase = P_SVC;
        end
        default: if (d) m_phase = P_IDLE;
      endcase
      m_pend = m_pend | rise;
      if (we) m_mask = wd;
    end
  endtask

  task automatic step(input bit r, input logic [15:0] s, input bit we,
                      input logic [15:0] wd, input bit a, input bit d);
    @(negedge clk);
    if (m_valid) begin
      check("pending", pending, m_pend);
      check("mask", mask, m_mask);
      check("enc_vec", enc_vec, m_pend & m_mask);
      check("irq_req", irq_req, (m_phase == P_REQ) ? 1 : 0);
      check("irq_id", irq_id, m_id);
    end
    rstn = r; irq_src = s; mask_we = we; mask_wdata = wd; irq_ack = a; irq_done = d;
    model_update(r, s, we, wd, a, d);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1, 16'h0, 0, 16'h0, 0, 0);
  endtask

  // Monitor: every rising irq_req must match the next predicted request.
  bit   prev_req = 1'b0;
  exp_t e;
  initial begin
    forever begin
      @(negedge clk);
      if (irq_req === 1'b1 && !prev_req) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_req: actual irq_id=%0d at cycle %0d, required no request", irq_id, cyc);
        end else begin
          e = exp_q.pop_front();
          check("req_id", irq_id, e.id);
          check("req_cycle", cyc, e.cyc);
        end
      end
      prev_req = (irq_req === 1'b1);
    end
  end

  logic [15:0] r_src, r_tog, r_wd;
  bit          r_we, r_ack, r_done, r_rst;

  initial begin
    step(0, 16'h0, 0, 16'h0, 0, 0);
    step(0, 16'h0, 0, 16'h0, 0, 0);

    // Single pulse on source 5, full handshake.
    step(1, 16'h0020, 0, 16'h0, 0, 0);
    step(1, 16'h0000, 0, 16'h0, 0, 0);
    spot("t1_pending", pending, 16'h0020);
    idle(1);
    spot("t1_req", irq_req, 1);
    spot("t1_id", irq_id, 5);
    step(1, 16'h0, 0, 16'h0, 1, 0);
    idle(1);
    spot("t1_ack_pending", pending, 16'h0000);
    spot("t1_ack_req", irq_req, 0);
    step(1, 16'h0, 0, 16'h0, 0, 1);
    idle(2);

    // Sources 3 and 12 together: 12 first, then 3 one edge after done.
    step(1, 16'h1008, 0, 16'h0, 0, 0);
    step(1, 16'h0000, 0, 16'h0, 0, 0);
    idle(1);
    spot("t2_id12", irq_id, 12);
    step(1, 16'h0, 0, 16'h0, 1, 0);
    step(1, 16'h0, 0, 16'h0, 0, 1);
    idle(1);
    spot("t2_idle_after_done", irq_req, 0);
    idle(1);
    spot("t2_req3", irq_req, 1);
    spot("t2_id3", irq_id, 3);
    step(1, 16'h0, 0, 16'h0, 1, 0);
    step(1, 16'h0, 0, 16'h0, 0, 1);
    idle(2);

    // Masked source goes pending but stays silent until enabled.
    step(1, 16'h0000, 1, 16'h0000, 0, 0);
    step(1, 16'h0080, 0, 16'h0, 0, 0);
    step(1, 16'h0000, 0, 16'h0, 0, 0);
    idle(2);
    spot("t3_pend7", pending, 16'h0080);
    spot("t3_enc0", enc_vec, 16'h0000);
    spot("t3_noreq", irq_req, 0);
    step(1, 16'h0, 1, 16'h0080, 0, 0);
    idle(2);
    spot("t3_req7", irq_req, 1);
    spot("t3_id7", irq_id, 7);
    step(1, 16'h0, 0, 16'h0, 1, 0);
    step(1, 16'h0, 0, 16'h0, 0, 1);
    step(1, 16'h0, 1, 16'hFFFF, 0, 0);
    idle(1);

    // Frozen id under a higher source; set wins over ack clear.
    step(1, 16'h0010, 0, 16'h0, 0, 0);
    step(1, 16'h0000, 0, 16'h0, 0, 0);
    idle(1);
    spot("t4_id4", irq_id, 4);
    step(1, 16'h0200, 0, 16'h0, 0, 0);
    step(1, 16'h0000, 0, 16'h0, 0, 0);
    spot("t4_id_frozen", irq_id, 4);
    step(1, 16'h0010, 0, 16'h0, 1, 0);
    step(1, 16'h0000, 0, 16'h0, 0, 0);
    spot("t4_pend4_kept", pending[4], 1);
    spot("t4_req_low", irq_req, 0);
    step(1, 16'h0, 0, 16'h0, 0, 1);
    idle(2);
    step(1, 16'h0, 0, 16'h0, 1, 0);
    step(1, 16'h0, 0, 16'h0, 0, 1);
    idle(2);
    step(1, 16'h0, 0, 16'h0, 1, 0);
    step(1, 16'h0, 0, 16'h0, 0, 1);
    idle(2);

    // Reset while in SERVICE with pending 0x0101, then a stray done.
    step(1, 16'h0002, 0, 16'h0, 0, 0);
    step(1, 16'h0000, 0, 16'h0, 0, 0);
    idle(1);
    step(1, 16'h0, 0, 16'h0, 1, 0);
    step(1, 16'h0101, 0, 16'h0, 0, 0);
    step(1, 16'h0000, 0, 16'h0, 0, 0);
    spot("t5_pend", pending, 16'h0101);
    step(0, 16'h0, 0, 16'h0, 0, 0);
    step(1, 16'h0, 0, 16'h0, 0, 1);
    spot("t5_rst_pend", pending, 16'h0000);
    spot("t5_rst_req", irq_req, 0);
    idle(2);
    spot("t5_done_ignored", irq_req, 0);

    // Random traffic.
    r_src = '0;
    for (int n = 0; n < 3000; n++) begin
      r_tog = '0;
      for (int b = 0; b < 16; b++) if ($urandom_range(0, 11) == 0) r_tog[b] = 1'b1;
      r_src  = r_src ^ r_tog;
      r_we   = ($urandom_range(0, 24) == 0);
      r_wd   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF;
      r_ack  = ($urandom_range(0, 2) == 0);
      r_done = ($urandom_range(0, 3) == 0);
      r_rst  = ($urandom_range(0, 399) != 0);
      step(r_rst, r_src, r_we, r_wd, r_ack, r_done);
    end
    idle(3);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
